jtag_bsr_chain: RTL



---
 rtl/jtag_bsr_chain.sv | 111 +++++++++++
 1 files changed

// File: rtl/jtag_bsr_chain.sv
// ---------------------------------------------------------------------------
// jtag_bsr_chain
//
// Parametrised boundary-scan data register with NUM_IN input cells
// (pin -> core) and NUM_OUT output cells (core -> pin). It sits between the
// chip pins and the core under test and is driven by TAP enable pulses in
// the single test-clock domain.
//
// Chain layout: bits [NUM_IN-1:0] are input cells and bits [LEN-1:NUM_IN]
// are output cells. tdi enters at the MSB, and the LSB leaves first on tdo.
//
// Optional feature macro: BSR_SHIFT_COUNT_EN
//   When defined, adds o_shift_cnt and o_chain_full. These report how many
//   bits have been shifted since the last capture, saturating at LEN.
//
// Ports:
//   i_clk         test clock; all state changes on the rising edge
//   i_rst         asynchronous reset, active-high
//   i_capture_dr  parallel-load the shift stage from {core_out, pin_in}
//   i_shift_dr    shift the chain one bit per cycle
//   i_update_dr   copy the shift stage into the update latches
//   i_intest      core_in comes from the update latches instead of the pins
//   i_extest      pin_out comes from the update latches instead of the core
//   i_tdi         serial scan in
//   o_tdo         serial scan out (registered, shift stage LSB)
//   i_pin_in      chip input pins
//   o_core_in     inputs presented to the core
//   i_core_out    core outputs
//   o_pin_out     chip output pins
//   o_shift_cnt   (BSR_SHIFT_COUNT_EN) bits shifted since capture, max LEN
//   o_chain_full  (BSR_SHIFT_COUNT_EN) o_shift_cnt == LEN
// ---------------------------------------------------------------------------
module jtag_bsr_chain #(
    parameter  int NUM_IN  = 4,
    parameter  int NUM_OUT = 4,
    localparam int LEN     = NUM_IN + NUM_OUT,
    localparam int CW      = $clog2(LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_capture_dr,
    input  logic               i_shift_dr,
    input  logic               i_update_dr,
    input  logic               i_intest,
    input  logic               i_extest,
    input  logic               i_tdi,
    output logic               o_tdo,
    input  logic [NUM_IN-1:0]  i_pin_in,
    output logic [NUM_IN-1:0]  o_core_in,
    input  logic [NUM_OUT-1:0] i_core_out,
    output logic [NUM_OUT-1:0] o_pin_out
`ifdef BSR_SHIFT_COUNT_EN
    ,
    output logic [CW-1:0]      o_shift_cnt,
    output logic               o_chain_full
`endif
);

    logic [LEN-1:0] r_sr;
    logic [LEN-1:0] r_ur;

    // Shift stage: capture has priority over shift. When neither is
    // asserted, the stage (and therefore tdo) holds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else if (i_capture_dr) begin
            r_sr <= {i_core_out, i_pin_in};
        end else if (i_shift_dr) begin
            r_sr <= {i_tdi, r_sr[LEN-1:1]};
        end
    end

    // Update latches sample the pre-edge shift stage, so an update that
    // coincides with a shift latches the contents before that shift.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ur <= '0;
        end else if (i_update_dr) begin
            r_ur <= r_sr;
        end
    end

    // tdo comes straight from a flop, so it only moves on a clock edge or reset.
    assign o_tdo = r_sr[0];

    // Mode muxes are purely combinational. The functional path stays
    // zero-latency, and mode changes apply in the same cycle.
    assign o_core_in = i_intest ? r_ur[NUM_IN-1:0]   : i_pin_in;
    assign o_pin_out = i_extest ? r_ur[LEN-1:NUM_IN] : i_core_out;

`ifdef BSR_SHIFT_COUNT_EN
    logic [CW-1:0] r_shift_cnt;

    // Clearing on capture mirrors the shift-stage priority. The count
    // saturates at LEN rather than wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift_cnt <= '0;
        end else if (i_capture_dr) begin
            r_shift_cnt <= '0;
        end else if (i_shift_dr && (r_shift_cnt != CW'(LEN))) begin
            r_shift_cnt <= r_shift_cnt + 1'b1;
        end
    end

    assign o_shift_cnt  = r_shift_cnt;
    assign o_chain_full = (r_shift_cnt == CW'(LEN));
`endif

endmodule
